// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled, majority-voted, LSB-first deserializer
// with optional parity and stop-bit checking.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  counter_CLK,
  input  logic                  counter_RST_ASYN,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_S0   = EW'(PRESCALE / 2 - 1);
  localparam logic [EW-1:0] E_S1   = EW'(PRESCALE / 2);
  localparam logic [EW-1:0] E_S2   = EW'(PRESCALE / 2 + 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic                  sync1;
  logic                  rx_s;
  logic [EW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [2:0]            smp;
  logic                  vote;
  logic [DATA_WIDTH-1:0] sreg;
  logic                  pen;
  logic                  ptyp;
  logic                  par_fail;
  logic                  bit_end;

  always_ff @(posedge counter_CLK or negedge counter_RST_ASYN) begin
    if (!counter_RST_ASYN) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      rx_s  <= sync1;
    end
  end

  assign vote = (smp[0] & smp[1]) |
                (smp[0] & smp[2]) |
                (smp[1] & smp[2]);

  assign bit_end = (edge_cnt == E_LAST);

  always_ff @(posedge counter_CLK or negedge counter_RST_ASYN) begin
    if (!counter_RST_ASYN) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      smp        <= '0;
      sreg       <= '0;
      pen        <= 1'b0;
      ptyp       <= 1'b0;
      par_fail   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + EW'(1);
        if (edge_cnt == E_S0) smp[0] <= rx_s;
        if (edge_cnt == E_S1) smp[1] <= rx_s;
        if (edge_cnt == E_S2) smp[2] <= rx_s;
      end

      unique case (state)
        IDLE: begin
          // The detecting cycle is edge 0 of the start bit.
          if (!rx_s) begin
            state    <= START;
            busy     <= 1'b1;
            edge_cnt <= EW'(1);
            bit_cnt  <= '0;
            pen      <= PAR_EN;
            ptyp     <= PAR_TYP;
            par_fail <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            if (vote) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            sreg <= {vote, sreg[DATA_WIDTH-1:1]};
            if (bit_cnt == B_LAST) begin
              bit_cnt <= '0;
              state   <= pen ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            par_fail <= (vote != ((^sreg) ^ ptyp));
            state    <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            state   <= IDLE;
            busy    <= 1'b0;
            par_err <= par_fail;
            stp_err <= ~vote;
            if (vote && !par_fail) begin
              data_out   <= sreg;
              data_valid <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: table of frames plus hand-written
// glitch, back-to-back and mid-frame reset sequences, checked by scoreboard.
module tb_uart_rx_deserializer;

  localparam int P = 8;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       pen;
  logic       ptyp;
  logic [7:0] data_out;
  logic       dv;
  logic       pe;
  logic       se;
  logic       busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] dout;
    int         cyc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    bit         pen;
    bit         ptyp;
    bit         pbit;
    bit         stop;
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] dout;
  } vec_t;

  exp_t q[$];

  uart_rx_deserializer #(
    .DATA_WIDTH(8),
    .PRESCALE  (P)
  ) dut (
    .counter_CLK     (clk),
    .counter_RST_ASYN(rst_n),
    .RX_IN           (rx),
    .PAR_EN          (pen),
    .PAR_TYP         (ptyp),
    .data_out        (data_out),
    .data_valid      (dv),
    .par_err         (pe),
    .stp_err         (se),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (dv || pe || se) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b expected none (cycle %0d)",
                 dv, pe, se, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("data_valid", 32'(dv), 32'(e.dv));
        chk("par_err", 32'(pe), 32'(e.pe));
        chk("stp_err", 32'(se), 32'(e.se));
        chk("data_out", 32'(data_out), 32'(e.dout));
        chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic goto(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1 rx = 1'b1;
    end
  endtask

  // Drives one frame cycle by cycle from the next clock edge on.
  task automatic send(input logic [7:0] d, input bit fpen,
                      input bit fptyp, input bit pbit, input bit stop,
                      input int gbit, input int cut, input bit push,
                      input bit edv, input bit epe, input bit ese,
                      input logic [7:0] edout);
    logic [15:0] fb;
    int f;
    int n;
    int c;
    exp_t e;
    fb = '1;
    fb[0] = 1'b0;
    for (int j = 0; j < 8; j++) fb[1+j] = d[j];
    if (fpen) begin
      fb[9]  = pbit;
      fb[10] = stop;
      f = 11;
    end else begin
      fb[9] = stop;
      f = 10;
    end
    n = (cut > 0) ? cut : f * P;
    @(posedge clk);
    #1;
    c = cyc;
    pen  = fpen;
    ptyp = fptyp;
    if (push) begin
      e.dv   = edv;
      e.pe   = epe;
      e.se   = ese;
      e.dout = edout;
      e.cyc  = c + 2 + f * P;
      q.push_back(e);
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      rx = fb[i / P];
      if ((i / P) == gbit && (i % P) == 4) rx = 1'b0;
    end
  endtask

  vec_t tbl[8];

  initial begin
    int c;
    tbl[0] = '{8'hA5, 0, 0, 0, 1, 1, 0, 0, 8'hA5};
    tbl[1] = '{8'h3C, 1, 0, 0, 1, 1, 0, 0, 8'h3C};
    tbl[2] = '{8'h3C, 1, 0, 1, 1, 0, 1, 0, 8'h3C};
    tbl[3] = '{8'h01, 1, 1, 0, 1, 1, 0, 0, 8'h01};
    tbl[4] = '{8'h55, 0, 0, 0, 0, 0, 0, 1, 8'h01};
    tbl[5] = '{8'h96, 1, 0, 1, 0, 0, 1, 1, 8'h01};
    tbl[6] = '{8'h80, 1, 1, 0, 1, 1, 0, 0, 8'h80};
    tbl[7] = '{8'hFF, 0, 0, 0, 1, 1, 0, 0, 8'hFF};

    rst_n = 1'b0;
    rx    = 1'b1;
    pen   = 1'b0;
    ptyp  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", 32'(data_out), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_pulses", 32'({dv, pe, se}), 32'h0);
    rst_n = 1'b1;
    idle(4);

    foreach (tbl[i]) begin
      send(tbl[i].d, tbl[i].pen, tbl[i].ptyp, tbl[i].pbit, tbl[i].stop,
           -1, 0, 1, tbl[i].dv, tbl[i].pe, tbl[i].se, tbl[i].dout);
      idle(6);
    end

    @(posedge clk);
    #1 rx = 1'b0;
    c = cyc;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rx = 1'b1;
    goto(c + 3);
    chk("glitch_busy_start", 32'(busy), 32'h1);
    goto(c + 9);
    chk("glitch_busy_last", 32'(busy), 32'h1);
    goto(c + 10);
    chk("glitch_busy_idle", 32'(busy), 32'h0);
    chk("glitch_data_out", 32'(data_out), 32'hFF);
    idle(4);

    send(8'hFF, 0, 0, 0, 1, 4, 0, 1, 1, 0, 0, 8'hFF);
    idle(4);

    send(8'h12, 0, 0, 0, 1, -1, 0, 1, 1, 0, 0, 8'h12);
    send(8'h34, 0, 0, 0, 1, -1, 0, 1, 1, 0, 0, 8'h34);
    idle(4);

    send(8'h77, 0, 0, 0, 1, -1, 40, 0, 0, 0, 0, 8'h00);
    chk("midframe_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'h0);
    chk("async_rst_data_out", 32'(data_out), 32'h0);
    chk("async_rst_pulses", 32'({dv, pe, se}), 32'h0);
    rx = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(5);
    send(8'hC3, 0, 0, 0, 1, -1, 0, 1, 1, 0, 0, 8'hC3);

    idle(100);
    chk("queue_empty", 32'(q.size()), 32'h0);
    chk("final_busy", 32'(busy), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
